sram_port_arbiter: RTL and testbench
====================================

// Module: sram_port_arbiter
// PURPOSE
//  Shares the single SRAM-like memory port between the IF requester (inst side) and the
//  MEM requester (data side). Data has priority, with a starvation guard for inst.
//  At most one transaction is outstanding on the memory port.
//  Honours the WB flush (wb_ClrStpJmp_out): an instruction response that is in flight
//  when the flush arrives is discarded.
// PARAMETERS
//  ADDR_W      32  address width
//  DATA_W      32  data width
//  STARVE_MAX  4   max consecutive data grants while inst_req is pending (range 1..15)
// PORTS
//  clk           in   1       clock
//  rst_n         in   1       synchronous reset, active-low
//  flush         in   1       WB ClrStpJmp; drops in-flight inst response
//  inst_req      in   1       IF read request (held until inst_addr_ok)
//  inst_addr     in   ADDR_W  IF read address
//  inst_addr_ok  out  1       1-cycle pulse: inst request accepted by memory
//  inst_data_ok  out  1       1-cycle pulse: inst_rdata valid
//  inst_rdata    out  DATA_W  inst read data
//  data_req      in   1       MEM request (held until data_addr_ok)
//  data_wr       in   1       1 = store, 0 = load
//  data_size     in   2       0 = byte, 1 = half, 2 = word
//  data_addr     in   ADDR_W  MEM address
//  data_wdata    in   DATA_W  store data
//  data_addr_ok  out  1       1-cycle pulse: data request accepted
//  data_data_ok  out  1       1-cycle pulse: load data valid / store done
//  data_rdata    out  DATA_W  load data
//  mem_req       out  1       memory-side request
//  mem_wr        out  1       memory-side write enable
//  mem_size      out  2       memory-side size
//  mem_addr      out  ADDR_W  memory-side address
//  mem_wdata     out  DATA_W  memory-side write data
//  mem_addr_ok   in   1       memory accepts request
//  mem_data_ok   in   1       memory response valid
//  mem_rdata     in   DATA_W  memory response data
// BEHAVIOUR
//  Reset: FSM = IDLE. All outputs 0. Owner = data. drop = 0. starve_cnt = 0.
//  FSM states: IDLE -> REQ -> RESP -> IDLE.
//  IDLE:
//   - Arbitrate when inst_req or data_req is high.
//   - Grant data, unless inst_req is high and starve_cnt == STARVE_MAX; then grant inst.
//   - Latch owner, wr, size, addr and wdata into registers (inst: wr=0, size=2).
//   - Go to REQ.
//  REQ:
//   - mem_req = 1; mem_* are driven from the latched registers and stay stable.
//   - On mem_addr_ok: pulse the owner's *_addr_ok in the same cycle, then go to RESP.
//  RESP:
//   - mem_req = 0.
//   - On mem_data_ok: route mem_rdata to the owner's *_rdata, pulse its *_data_ok
//     (suppressed when owner = inst and drop = 1), clear drop, go to IDLE.
//  Latency:
//   - Request seen in IDLE at cycle t -> mem_req high at t+1.
//   - Minimum round trip is 3 cycles, because mem_addr_ok and mem_data_ok cannot both
//     be honoured in one state.
//  Flush:
//   - flush while owner = inst and FSM in REQ or RESP sets drop.
//   - The request is not withdrawn: an SRAM-like request must stay high until accepted.
//   - flush in IDLE does nothing.
//   - Data transactions are never dropped; MEM cancels squashed stores before requesting.
//  flush together with mem_data_ok in RESP (owner = inst): inst_data_ok is suppressed.
//  starve_cnt:
//   - +1 on each data grant while inst_req is high; saturates at STARVE_MAX.
//   - Cleared on each inst grant, and on a data grant while inst_req is low.
//  *_rdata holds its value between responses. Outputs are ignored except during *_data_ok.
//  Reset mid-transaction returns to IDLE. Any outstanding memory response is then not
//  tracked; the memory side is reset by the same rst_n.
// TESTING
//  1. inst_req only, addr 0xBFC00000; mem_addr_ok 1 cycle after mem_req, mem_data_ok
//     2 cycles later with 0x3C1D0001
//     -> inst_addr_ok pulse; inst_data_ok with inst_rdata = 0x3C1D0001;
//        data_* outputs never pulse.
//  2. inst_req and data_req high in the same IDLE cycle (store, size 2, 0x80001000,
//     0xDEADBEEF)
//     -> data served first with mem_wr=1, mem_wdata=0xDEADBEEF; inst served after
//        data_data_ok.
//  3. data_req held continuously and inst_req held, STARVE_MAX=4
//     -> 4 data grants, then 1 inst grant, then starve_cnt = 0.
//  4. inst transaction; flush pulses in RESP before mem_data_ok
//     -> inst_data_ok stays 0; the next inst request completes normally.
//  5. flush in the same cycle as mem_data_ok for a data load (0x12345678)
//     -> data_data_ok = 1, data_rdata = 0x12345678.
//  6. rst_n low for 1 cycle while in REQ
//     -> next cycle mem_req = 0, FSM = IDLE, all ok pulses 0.

Source files
------------

// File: rtl/sram_port_arbiter_if.sv
// Bundled handshake signals of the inst requester, data requester and the shared memory port.
// The arbiter takes the master view; requesters and memory together take the slave view.
interface sram_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              inst_req;
  logic [ADDR_W-1:0] inst_addr;
  logic              inst_addr_ok;
  logic              inst_data_ok;
  logic [DATA_W-1:0] inst_rdata;

  logic              data_req;
  logic              data_wr;
  logic [1:0]        data_size;
  logic [ADDR_W-1:0] data_addr;
  logic [DATA_W-1:0] data_wdata;
  logic              data_addr_ok;
  logic              data_data_ok;
  logic [DATA_W-1:0] data_rdata;

  logic              mem_req;
  logic              mem_wr;
  logic [1:0]        mem_size;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_addr_ok;
  logic              mem_data_ok;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    input  inst_req, inst_addr,
    input  data_req, data_wr, data_size, data_addr, data_wdata,
    input  mem_addr_ok, mem_data_ok, mem_rdata,
    output inst_addr_ok, inst_data_ok, inst_rdata,
    output data_addr_ok, data_data_ok, data_rdata,
    output mem_req, mem_wr, mem_size, mem_addr, mem_wdata
  );

  modport slave (
    output inst_req, inst_addr,
    output data_req, data_wr, data_size, data_addr, data_wdata,
    output mem_addr_ok, mem_data_ok, mem_rdata,
    input  inst_addr_ok, inst_data_ok, inst_rdata,
    input  data_addr_ok, data_data_ok, data_rdata,
    input  mem_req, mem_wr, mem_size, mem_addr, mem_wdata
  );
endinterface

// File: rtl/sram_port_arbiter.sv
// Shares one SRAM-like memory port between the inst and data requesters, one transaction
// outstanding; data has priority with a starvation guard, and a WB flush drops an in-flight inst response.
module sram_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  sram_port_arbiter_if.master  bus
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t            state_r;
  state_t            state_nxt_s;

  logic              grant_any_s;
  logic              grant_inst_s;

  logic              owner_inst_r;
  logic              wr_r;
  logic [1:0]        size_r;
  logic [ADDR_W-1:0] addr_r;
  logic [DATA_W-1:0] wdata_r;
  logic              drop_r;
  logic [3:0]        starve_cnt_r;
  logic [DATA_W-1:0] inst_rdata_r;
  logic [DATA_W-1:0] data_rdata_r;

  logic              mem_req_s;
  logic              inst_aok_s;
  logic              data_aok_s;
  logic              inst_dok_s;
  logic              data_dok_s;

  // Arbitration: data wins unless inst has waited through STARVE_MAX data grants.
  always_comb begin
    grant_any_s = bus.inst_req | bus.data_req;
    if (bus.inst_req && (!bus.data_req || (starve_cnt_r == STARVE_LIM))) begin
      grant_inst_s = 1'b1;
    end else begin
      grant_inst_s = 1'b0;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic; address and data phases never share a state.
  always_comb begin
    state_nxt_s = ST_IDLE;
    case (state_r)
      ST_IDLE: begin
        if (grant_any_s) begin
          state_nxt_s = ST_REQ;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (bus.mem_addr_ok) begin
          state_nxt_s = ST_RESP;
        end else begin
          state_nxt_s = ST_REQ;
        end
      end
      ST_RESP: begin
        if (bus.mem_data_ok) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_RESP;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // FSM outputs: request strobe and the owner's handshake pulses.
  always_comb begin
    mem_req_s  = 1'b0;
    inst_aok_s = 1'b0;
    data_aok_s = 1'b0;
    inst_dok_s = 1'b0;
    data_dok_s = 1'b0;
    case (state_r)
      ST_REQ: begin
        mem_req_s = 1'b1;
        if (bus.mem_addr_ok) begin
          inst_aok_s = owner_inst_r;
          data_aok_s = ~owner_inst_r;
        end else begin
          inst_aok_s = 1'b0;
          data_aok_s = 1'b0;
        end
      end
      ST_RESP: begin
        if (bus.mem_data_ok) begin
          // A flush arriving together with the response still squashes it.
          inst_dok_s = owner_inst_r & ~drop_r & ~flush;
          data_dok_s = ~owner_inst_r;
        end else begin
          inst_dok_s = 1'b0;
          data_dok_s = 1'b0;
        end
      end
      default: begin
        mem_req_s = 1'b0;
      end
    endcase
  end

  // Latch the granted transaction so mem_* stay stable until accepted.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      owner_inst_r <= 1'b0;
      wr_r         <= 1'b0;
      size_r       <= 2'd0;
      addr_r       <= {ADDR_W{1'b0}};
      wdata_r      <= {DATA_W{1'b0}};
    end else if ((state_r == ST_IDLE) && grant_any_s) begin
      if (grant_inst_s) begin
        owner_inst_r <= 1'b1;
        wr_r         <= 1'b0;
        size_r       <= 2'd2;
        addr_r       <= bus.inst_addr;
        wdata_r      <= {DATA_W{1'b0}};
      end else begin
        owner_inst_r <= 1'b0;
        wr_r         <= bus.data_wr;
        size_r       <= bus.data_size;
        addr_r       <= bus.data_addr;
        wdata_r      <= bus.data_wdata;
      end
    end
  end

  // Starvation counter: counts data grants that bypassed a waiting inst request.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      starve_cnt_r <= 4'd0;
    end else if ((state_r == ST_IDLE) && grant_any_s) begin
      if (grant_inst_s || !bus.inst_req) begin
        starve_cnt_r <= 4'd0;
      end else if (starve_cnt_r != STARVE_LIM) begin
        starve_cnt_r <= starve_cnt_r + 4'd1;
      end
    end
  end

  // Drop flag: the request cannot be withdrawn, so the inst response is discarded instead.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      drop_r <= 1'b0;
    end else if ((state_r == ST_RESP) && bus.mem_data_ok) begin
      drop_r <= 1'b0;
    end else if (flush && owner_inst_r && ((state_r == ST_REQ) || (state_r == ST_RESP))) begin
      drop_r <= 1'b1;
    end
  end

  // Read data holding registers, refreshed only on a delivered response.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      inst_rdata_r <= {DATA_W{1'b0}};
      data_rdata_r <= {DATA_W{1'b0}};
    end else begin
      if (inst_dok_s) begin
        inst_rdata_r <= bus.mem_rdata;
      end
      if (data_dok_s) begin
        data_rdata_r <= bus.mem_rdata;
      end
    end
  end

  assign bus.mem_req      = mem_req_s;
  assign bus.mem_wr       = wr_r;
  assign bus.mem_size     = size_r;
  assign bus.mem_addr     = addr_r;
  assign bus.mem_wdata    = wdata_r;

  assign bus.inst_addr_ok = inst_aok_s;
  assign bus.inst_data_ok = inst_dok_s;
  assign bus.inst_rdata   = inst_dok_s ? bus.mem_rdata : inst_rdata_r;

  assign bus.data_addr_ok = data_aok_s;
  assign bus.data_data_ok = data_dok_s;
  assign bus.data_rdata   = data_dok_s ? bus.mem_rdata : data_rdata_r;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter: a small SRAM-like memory model plus requesters
// that hold their request until addr_ok; expected values are hand-computed constants.
module tb_sram_port_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush;

  always #5 clk = ~clk;

  sram_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  sram_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Requesters: a request stays high while more have been issued than accepted.
  int inst_want = 0, inst_got = 0, data_want = 0, data_got = 0;
  assign bus.inst_req = (inst_want != inst_got);
  assign bus.data_req = (data_want != data_got);

  // Memory model settings and observation logs.
  int          addr_lat = 1;
  int          data_lat = 2;
  int          req_wait = 1;
  int          resp_wait = 0;
  bit          resp_pend = 1'b0;
  logic [31:0] rsp_word = 32'h0;
  bit          flush_resp_mode = 1'b0;
  bit          flush_data_mode = 1'b0;
  int          cyc = 0;

  logic        g_inst [0:63];
  logic        g_wr   [0:63];
  logic [1:0]  g_size [0:63];
  logic [31:0] g_addr [0:63];
  logic [31:0] g_wdat [0:63];
  int          n_grant = 0;
  int          inst_dok_cnt = 0, data_dok_cnt = 0;
  logic [31:0] inst_rdata_seen = 32'h0, data_rdata_seen = 32'h0;
  int          last_inst_aok_cyc = 0, last_data_dok_cyc = 0;

  // Memory model drives at negedge, then the monitor samples 1 time unit later.
  initial begin
    bus.mem_addr_ok = 1'b0;
    bus.mem_data_ok = 1'b0;
    bus.mem_rdata   = 32'h0;
    flush           = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      bus.mem_addr_ok = 1'b0;
      bus.mem_data_ok = 1'b0;
      flush = 1'b0;
      if (!rst_n) begin
        resp_pend = 1'b0;
        req_wait  = addr_lat;
      end else if (resp_pend) begin
        if (resp_wait == 0) begin
          bus.mem_data_ok = 1'b1;
          bus.mem_rdata   = rsp_word;
          flush           = flush_data_mode;
          resp_pend       = 1'b0;
        end else begin
          resp_wait--;
          flush = flush_resp_mode;
        end
      end else if (bus.mem_req) begin
        if (req_wait == 0) begin
          bus.mem_addr_ok = 1'b1;
          resp_pend = 1'b1;
          resp_wait = data_lat - 1;
          req_wait  = addr_lat;
        end else begin
          req_wait--;
        end
      end else begin
        req_wait = addr_lat;
      end
      #1;
      if ((bus.inst_addr_ok || bus.data_addr_ok) && n_grant < 64) begin
        g_inst[n_grant] = bus.inst_addr_ok;
        g_wr[n_grant]   = bus.mem_wr;
        g_size[n_grant] = bus.mem_size;
        g_addr[n_grant] = bus.mem_addr;
        g_wdat[n_grant] = bus.mem_wdata;
        n_grant++;
      end
      if (bus.inst_addr_ok) begin
        inst_got++;
        last_inst_aok_cyc = cyc;
      end
      if (bus.data_addr_ok) data_got++;
      if (bus.inst_data_ok) begin
        inst_dok_cnt++;
        inst_rdata_seen = bus.inst_rdata;
      end
      if (bus.data_data_ok) begin
        data_dok_cnt++;
        data_rdata_seen = bus.data_rdata;
        last_data_dok_cyc = cyc;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  int g0, i0, d0, ia0;
  bit found;
  logic exp_inst;

  initial begin
    bus.inst_addr  = 32'h0;
    bus.data_wr    = 1'b0;
    bus.data_size  = 2'd2;
    bus.data_addr  = 32'h0;
    bus.data_wdata = 32'h0;
    rst_n = 1'b0;
    step(3);
    chk("rst_mem_req",   64'(bus.mem_req), 64'd0);
    chk("rst_mem_wr",    64'(bus.mem_wr), 64'd0);
    chk("rst_mem_addr",  64'(bus.mem_addr), 64'd0);
    chk("rst_inst_aok",  64'(bus.inst_addr_ok), 64'd0);
    chk("rst_inst_dok",  64'(bus.inst_data_ok), 64'd0);
    chk("rst_data_aok",  64'(bus.data_addr_ok), 64'd0);
    chk("rst_data_dok",  64'(bus.data_data_ok), 64'd0);
    chk("rst_inst_rdat", 64'(bus.inst_rdata), 64'd0);
    chk("rst_data_rdat", 64'(bus.data_rdata), 64'd0);
    rst_n = 1'b1;
    step(2);

    // 1: lone inst fetch, mem_req one cycle after the request.
    rsp_word = 32'h3C1D0001;
    bus.inst_addr = 32'hBFC00000;
    g0 = n_grant;
    inst_want++;
    step(1);
    chk("t1_latency_mem_req", 64'(bus.mem_req), 64'd1);
    step(11);
    chk("t1_grants",    64'(n_grant - g0), 64'd1);
    chk("t1_owner",     64'(g_inst[g0]), 64'd1);
    chk("t1_addr",      64'(g_addr[g0]), 64'hBFC00000);
    chk("t1_wr",        64'(g_wr[g0]), 64'd0);
    chk("t1_size",      64'(g_size[g0]), 64'd2);
    chk("t1_inst_dok",  64'(inst_dok_cnt), 64'd1);
    chk("t1_inst_rdat", 64'(inst_rdata_seen), 64'h3C1D0001);
    chk("t1_data_aok",  64'(data_got), 64'd0);
    chk("t1_data_dok",  64'(data_dok_cnt), 64'd0);

    // 2: simultaneous requests, data store goes first.
    rsp_word = 32'h8C080000;
    bus.inst_addr  = 32'hBFC00004;
    bus.data_wr    = 1'b1;
    bus.data_size  = 2'd2;
    bus.data_addr  = 32'h80001000;
    bus.data_wdata = 32'hDEADBEEF;
    g0 = n_grant; i0 = inst_dok_cnt; d0 = data_dok_cnt;
    inst_want++;
    data_want++;
    step(20);
    chk("t2_grants",     64'(n_grant - g0), 64'd2);
    chk("t2_first_data", 64'(g_inst[g0]), 64'd0);
    chk("t2_mem_wr",     64'(g_wr[g0]), 64'd1);
    chk("t2_mem_addr",   64'(g_addr[g0]), 64'h80001000);
    chk("t2_mem_wdata",  64'(g_wdat[g0]), 64'hDEADBEEF);
    chk("t2_second_inst",64'(g_inst[g0+1]), 64'd1);
    chk("t2_inst_addr",  64'(g_addr[g0+1]), 64'hBFC00004);
    chk("t2_inst_after_data", 64'(last_inst_aok_cyc > last_data_dok_cyc), 64'd1);
    chk("t2_data_dok",   64'(data_dok_cnt - d0), 64'd1);
    chk("t2_inst_dok",   64'(inst_dok_cnt - i0), 64'd1);
    chk("t2_inst_rdat",  64'(inst_rdata_seen), 64'h8C080000);

    // 3: continuous data load stream with inst pending: D D D D I D D D D I D D.
    bus.data_wr   = 1'b0;
    bus.data_addr = 32'h80002000;
    bus.inst_addr = 32'hBFC00008;
    g0 = n_grant;
    data_want += 10;
    inst_want += 2;
    step(80);
    chk("t3_grants", 64'(n_grant - g0), 64'd12);
    for (int i = 0; i < 12; i++) begin
      exp_inst = (i == 4) || (i == 9);
      chk($sformatf("t3_owner_%0d", i), 64'(g_inst[g0+i]), 64'(exp_inst));
    end

    // 4: flush while the inst response is pending drops it; next fetch is normal.
    flush_resp_mode = 1'b1;
    rsp_word = 32'h11111111;
    bus.inst_addr = 32'hBFC00010;
    i0 = inst_dok_cnt; ia0 = inst_got;
    inst_want++;
    step(12);
    chk("t4_inst_accepted", 64'(inst_got - ia0), 64'd1);
    chk("t4_inst_dropped",  64'(inst_dok_cnt - i0), 64'd0);
    flush_resp_mode = 1'b0;
    rsp_word = 32'h24080005;
    inst_want++;
    step(12);
    chk("t4_next_inst_dok",  64'(inst_dok_cnt - i0), 64'd1);
    chk("t4_next_inst_rdat", 64'(inst_rdata_seen), 64'h24080005);

    // 5: flush with mem_data_ok: data load delivered, inst response suppressed.
    flush_data_mode = 1'b1;
    rsp_word = 32'h12345678;
    bus.data_addr = 32'h80004000;
    d0 = data_dok_cnt;
    data_want++;
    step(12);
    chk("t5_data_dok",  64'(data_dok_cnt - d0), 64'd1);
    chk("t5_data_rdat", 64'(data_rdata_seen), 64'h12345678);
    rsp_word = 32'h55AA55AA;
    i0 = inst_dok_cnt; ia0 = inst_got;
    inst_want++;
    step(12);
    chk("t5_inst_accepted",   64'(inst_got - ia0), 64'd1);
    chk("t5_inst_suppressed", 64'(inst_dok_cnt - i0), 64'd0);
    flush_data_mode = 1'b0;

    // 6: reset while in REQ returns to IDLE with all pulses low.
    addr_lat = 5;
    ia0 = inst_got;
    inst_want++;
    found = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (!found) begin
        step(1);
        found = bus.mem_req;
      end
    end
    chk("t6_reached_req", 64'(found), 64'd1);
    rst_n = 1'b0;
    inst_want = inst_got;
    step(1);
    chk("t6_mem_req",  64'(bus.mem_req), 64'd0);
    chk("t6_inst_aok", 64'(bus.inst_addr_ok), 64'd0);
    chk("t6_data_aok", 64'(bus.data_addr_ok), 64'd0);
    chk("t6_inst_dok", 64'(bus.inst_data_ok), 64'd0);
    chk("t6_data_dok", 64'(bus.data_data_ok), 64'd0);
    chk("t6_no_accept", 64'(inst_got - ia0), 64'd0);
    rst_n = 1'b1;
    addr_lat = 1;
    step(2);
    chk("t6_idle_after", 64'(bus.mem_req), 64'd0);

    // Recovery: a data load completes normally after reset.
    rsp_word = 32'hA5A55A5A;
    bus.data_addr = 32'h80003000;
    d0 = data_dok_cnt;
    data_want++;
    step(12);
    chk("t6_recover_dok",  64'(data_dok_cnt - d0), 64'd1);
    chk("t6_recover_rdat", 64'(data_rdata_seen), 64'hA5A55A5A);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
